// File: rtl/fsqrt_pkg.sv
// fsqrt_pkg: shared states, IEEE-754 single constants and field widths for fsqrt_seq
package fsqrt_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;
  typedef enum logic [1:0] {IDLE, LOOKUP, ITER, DONE} state_t;
endpackage

// File: rtl/fsqrt_classify.sv
// fsqrt_classify: decodes an IEEE-754 single into the classes that bypass the Newton path
module fsqrt_classify
  import fsqrt_pkg::*;
(
  input  logic [31:0] i_data,
  output logic        o_is_zero,
  output logic        o_is_neg,
  output logic        o_is_inf,
  output logic        o_is_nan
);
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  assign w_exp     = i_data[30:23];
  assign w_man     = i_data[22:0];
  assign o_is_zero = w_exp == '0;
  assign o_is_inf  = (w_exp == '1) && (w_man == '0);
  assign o_is_nan  = (w_exp == '1) && (w_man != '0);
  assign o_is_neg  = i_data[31] && !o_is_zero;
endmodule

// File: rtl/fsqrt_seq.sv
// fsqrt_seq: sequential sqrt controller around external guess/Newton stages; FSQRT_SEQ_SPECIAL_EN enables special-case bypass
module fsqrt_seq
  import fsqrt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [31:0] tbl_s,
  input  logic [63:0] tbl_x,
  output logic [31:0] nwt_s,
  output logic [63:0] nwt_x,
  input  logic [31:0] nwt_d,
  output logic        busy
);
  state_t      r_state, w_next, w_start;
  logic [31:0] r_op, r_res;
  logic [63:0] r_x;
  logic        w_acc, w_byp_en;
`ifdef FSQRT_SEQ_SPECIAL_EN
  logic        w_zero, w_neg, w_inf, w_nan;
  logic [31:0] w_byp;
  fsqrt_classify u_cls (
    .i_data   (in_data),
    .o_is_zero(w_zero),
    .o_is_neg (w_neg),
    .o_is_inf (w_inf),
    .o_is_nan (w_nan)
  );
  assign w_byp_en = w_zero | w_neg | w_inf | w_nan;
  assign w_byp    = w_zero ? {in_data[31], 31'b0} : (w_neg | w_nan) ? QNAN : PINF;
`else
  assign w_byp_en = 1'b0;
`endif
  assign in_ready  = (r_state == IDLE) || (r_state == DONE && out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_start   = w_byp_en ? DONE : LOOKUP;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign out_data  = r_res;
  assign tbl_s     = r_op;
  assign nwt_s     = r_op;
  assign nwt_x     = r_x;
  // next state: one pass through LOOKUP and ITER, results held in DONE until consumed
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? w_start : IDLE;
      LOOKUP:  w_next = ITER;
      ITER:    w_next = DONE;
      DONE:    w_next = out_ready ? (w_acc ? w_start : IDLE) : DONE;
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // operand, guess and result registers; each loads only in its own phase
  always_ff @(posedge clk)
    if (rst) begin
      r_op  <= '0;
      r_x   <= '0;
      r_res <= '0;
    end else begin
      if (w_acc) r_op <= in_data;
      if (r_state == LOOKUP) r_x <= tbl_x;
      if (r_state == ITER) r_res <= nwt_d;
`ifdef FSQRT_SEQ_SPECIAL_EN
      if (w_acc && w_byp_en) r_res <= w_byp;
`endif
    end
endmodule

// File: tb/tb_fsqrt_seq.sv
// tb_fsqrt_seq: table-driven and scoreboard checks of fsqrt_seq with behavioural guess/Newton stages
module tb_fsqrt_seq;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data, tbl_s, nwt_s, nwt_d;
  logic [63:0] tbl_x, nwt_x;
  int          tests = 0, fails = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    int          lat;
  } vec_t;
  vec_t vt[$];

`ifdef FSQRT_SEQ_SPECIAL_EN
  localparam int BL = 1;
  localparam logic [31:0] NEG_R = 32'h7FC00000, NZ_R = 32'h80000000, DEN_R = 32'h00000000;
`else
  localparam int BL = 3;
  localparam logic [31:0] NEG_R = 32'h7F800001, NZ_R = 32'h7F800001, DEN_R = 32'h7FC00000;
`endif

  fsqrt_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .tbl_s(tbl_s), .tbl_x(tbl_x), .nwt_s(nwt_s), .nwt_x(nwt_x), .nwt_d(nwt_d), .busy(busy)
  );

  function automatic logic [31:0] ext_sqrt(input logic [31:0] s);
    case (s)
      32'h40800000: return 32'h40000000;
      32'h40000000: return 32'h3FB504F3;
      32'h3F800000: return 32'h3F800000;
      32'h41100000: return 32'h40400000;
      32'h41800000: return 32'h40800000;
      32'h00000000: return 32'h00000000;
      32'h7F800000: return 32'h7F800000;
      default:      return s[31] ? 32'h7F800001 : 32'h7FC00000;
    endcase
  endfunction

  // external stages: the guess encodes its operand so the Newton model can tell a stale or wrong guess
  assign tbl_x = {tbl_s, ~tbl_s};
  assign nwt_d = (nwt_x == {nwt_s, ~nwt_s}) ? ext_sqrt(nwt_s) : 32'hDEADBEEF;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every consumed result must match the oldest outstanding expectation
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h want none", out_data);
      end else check("sb_data", 64'(out_data), 64'(sb.pop_front()));
    end

  task automatic run_op(input logic [31:0] d, input logic [31:0] e, input int lat);
    int n, b;
    in_valid = 1;
    in_data  = d;
    sb.push_back(e);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    step();
    in_valid = 0;
    in_data  = 32'hA5A5A5A5;
    n = 1;
    b = int'(busy);
    while (!out_valid && n < 20) begin
      step();
      n++;
      b += int'(busy);
    end
    check("latency", 64'(n), 64'(lat));
    check("busy_cycles", 64'(b), 64'(lat));
    step();
    check("idle_after", 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    vt.push_back('{32'h40800000, 32'h40000000, 3});
    vt.push_back('{32'h40000000, 32'h3FB504F3, 3});
    vt.push_back('{32'h3F800000, 32'h3F800000, 3});
    vt.push_back('{32'h41100000, 32'h40400000, 3});
    vt.push_back('{32'h41800000, 32'h40800000, 3});
    vt.push_back('{32'hBF800000, NEG_R, BL});
    vt.push_back('{32'h00000000, 32'h00000000, BL});
    vt.push_back('{32'h7F800000, 32'h7F800000, BL});
    vt.push_back('{32'h80000000, NZ_R, BL});
    vt.push_back('{32'h00000001, DEN_R, BL});
    vt.push_back('{32'h7FC00001, 32'h7FC00000, BL});
    rst = 1; in_valid = 1; in_data = 32'h40800000; out_ready = 1;
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_tbl_s", 64'(tbl_s), 64'(0));
    check("rst_nwt_s", 64'(nwt_s), 64'(0));
    check("rst_nwt_x", nwt_x, 64'(0));
    in_valid = 0;
    rst = 0;
    step();
    foreach (vt[i]) run_op(vt[i].din, vt[i].dout, vt[i].lat);
    // held result: output frozen and operand offers ignored while consumer stalls
    out_ready = 0; in_valid = 1; in_data = 32'h40000000;
    sb.push_back(32'h3FB504F3);
    step();
    in_data = 32'h41100000;
    n = 1;
    while (!out_valid && n < 20) begin step(); n++; end
    check("hold_latency", 64'(n), 64'(3));
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", 64'(out_data), 64'(32'h3FB504F3));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      step();
    end
    out_ready = 1;
    sb.push_back(32'h40400000);
    step();
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 20) begin step(); n++; end
    check("b2b_after_hold_latency", 64'(n), 64'(3));
    step();
    // back-to-back stream with a result every third cycle
    in_valid = 1; in_data = 32'h3F800000;
    sb.push_back(32'h3F800000);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("stream_valid", 64'(out_valid), 64'(k % 3 == 0));
      if (k == 3) begin in_data = 32'h41100000; sb.push_back(32'h40400000); end
      if (k == 6) begin in_data = 32'h41800000; sb.push_back(32'h40800000); end
      if (k == 9) in_valid = 0;
    end
    step();
    check("stream_idle", 64'(busy), 64'(0));
    // reset in ITER discards the operation
    in_valid = 1; in_data = 32'h40800000;
    step();
    in_valid = 0;
    step();
    check("iter_busy", 64'(busy), 64'(1));
    rst = 1;
    sb.delete();
    step();
    rst = 0;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_data", 64'(out_data), 64'(0));
    check("midrst_nwt_x", nwt_x, 64'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      check("midrst_no_out", 64'(out_valid), 64'(0));
    end
    run_op(32'h40800000, 32'h40000000, 3);
    step();
    step();
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fsqrt_seq.md
FSQRT_SEQ -- requirements
Module: fsqrt_seq

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  operand offered; in_data  input  32  IEEE-754 single operand.
REQ-004 SHALL have: in_ready  output  1  operand accepted on an edge where in_valid && in_ready.
REQ-005 SHALL have: out_valid  output  1  result held; out_data  output  32  sqrt result; out_ready  input  1  consumer accepts.
REQ-006 SHALL have: tbl_s  output  32  operand to the initial-guess stage; tbl_x  input  64  initial guess returned combinationally.
REQ-007 SHALL have: nwt_s  output  32  operand to the Newton/round stage; nwt_x  output  64  registered guess; nwt_d  input  32  rounded result returned combinationally.
REQ-008 SHALL have: busy  output  1  high in any state other than IDLE.

Function
REQ-009 FSM states SHALL be IDLE, LOOKUP, ITER, DONE.
REQ-010 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-011 On accept, the SHALL latch in_data into op_q and go to LOOKUP (or DONE per REQ-017).
REQ-012 tbl_s and nwt_s SHALL both be driven from op_q, never directly from in_data.
REQ-013 In LOOKUP, the next edge SHALL latch tbl_x into x_q and go to ITER; nwt_x SHALL be x_q.
REQ-014 In ITER, the next edge SHALL latch nwt_d into res_q and go to DONE; out_data SHALL be res_q.
REQ-015 Latency: out_valid SHALL be high immediately after the 3rd rising edge counting the accepting edge (accept, LOOKUP, ITER).
REQ-016 In DONE, out_valid=1 and out_data stable until out_ready; on out_ready: if in_valid, accept new op (back-to-back, no idle cycle), else go to IDLE.
REQ-017 Special-case bypass (macro-gated, REQ-022): exponent==0 (zero or denormal) yields {sign,31'b0}; sign=1 with non-zero magnitude yields 32'h7FC00000; exponent==255 with mantissa==0 and sign=0 yields 32'h7F800000; exponent==255 with mantissa!=0 yields 32'h7FC00000; bypass ops SHALL go directly to DONE on the accepting edge (out_valid after 1 edge).
REQ-018 in_valid without in_ready SHALL be ignored; in_data SHALL NOT be sampled outside an accept edge.
REQ-019 out_valid SHALL never drop without out_ready; x_q/res_q SHALL not change in DONE.

Reset
REQ-020 On rst at any edge, including mid-operation: state=IDLE, out_valid=0, busy=0, op_q=0, x_q=0, res_q=0; in-flight op discarded, no output produced.
REQ-021 Outputs after reset: in_ready=1, out_data=0, tbl_s=0, nwt_s=0, nwt_x=0.

Configuration
REQ-022 Macro FSQRT_SEQ_SPECIAL_EN: defined -> REQ-017 bypass active; undefined -> all operands go through LOOKUP/ITER and out_data is whatever nwt_d returns (e.g. 32'h7F800001 for negative inputs).

Structure
REQ-023 Package fsqrt_pkg SHALL hold the state enum, constants QNAN=32'h7FC00000, PINF=32'h7F800000, and field-width localparams (EXP_W=8, MAN_W=23).
REQ-024 One sub-module fsqrt_classify SHALL decode in_data into is_zero, is_neg, is_inf, is_nan, used only under FSQRT_SEQ_SPECIAL_EN.
REQ-025 Initial-guess and Newton stages SHALL remain external; this block contains no arithmetic beyond classification.

Verification
REQ-026 in_data=32'h40800000 (4.0), out_ready=1 -> out_data=32'h40000000, out_valid after 3 edges counting accept, busy high for 3 cycles.
REQ-027 in_data=32'h40000000 (2.0) -> out_data=32'h3FB504F3; hold out_ready=0 for 5 cycles -> out_valid and out_data unchanged, in_ready=0 throughout.
REQ-028 With macro: 32'hBF800000 -> 32'h7FC00000 after 1 edge; 32'h00000000 -> 32'h00000000; 32'h7F800000 -> 32'h7F800000; without macro: 32'hBF800000 -> 32'h7F800001 after 3 edges.
REQ-029 Back-to-back: stream 1.0, 9.0, 16.0 with in_valid and out_ready held 1 -> outputs 32'h3F800000, 32'h40400000, 32'h40800000, one result every 3 cycles, no gap.
REQ-030 Assert rst during ITER -> next cycle IDLE, out_valid=0, no result emitted; subsequent op 4.0 -> 32'h40000000 correctly.
